// File: rtl/rpxx_pkg.sv
// rpxx_pkg: shared definitions for the RPxx disk-address unit.
//  - register field offsets inside rpDA / rpDC
//  - default field widths
//  - geometry (last legal sector/track/cylinder) for RP06 and RP07 packs
package rpxx_pkg;

  // Field offsets inside the 16-bit RPDA / RPDC register images
  localparam int rpDA_SA_LSB = 0;
  localparam int rpDA_TA_LSB = 8;
  localparam int rpDC_CA_LSB = 0;

  // Default widths
  localparam int DEF_DATA_W = 36;
  localparam int DEF_SA_W   = 6;
  localparam int DEF_TA_W   = 6;
  localparam int DEF_CA_W   = 10;

  // Drive geometry: values are the LAST legal number of each field
  localparam logic [7:0]  RP06_SEC_NUM = 8'd19;
  localparam logic [7:0]  RP06_TRK_NUM = 8'd18;
  localparam logic [15:0] RP06_CYL_NUM = 16'd814;
  localparam logic [7:0]  RP07_SEC_NUM = 8'd42;
  localparam logic [7:0]  RP07_TRK_NUM = 8'd31;
  localparam logic [15:0] RP07_CYL_NUM = 16'd629;

  typedef enum logic [0:0] {
    DRV_RP06 = 1'b0,
    DRV_RP07 = 1'b1
  } rpxx_drv_e;

  typedef struct packed {
    logic [7:0]  sec;
    logic [7:0]  trk;
    logic [15:0] cyl;
  } rpxx_geom_t;

  // Geometry lookup by drive type, used to drive secNum/trkNum/cylNum
  function automatic rpxx_geom_t rpxx_geom(input rpxx_drv_e drv);
    rpxx_geom_t g;
    case (drv)
      DRV_RP06: g = '{sec: RP06_SEC_NUM, trk: RP06_TRK_NUM, cyl: RP06_CYL_NUM};
      DRV_RP07: g = '{sec: RP07_SEC_NUM, trk: RP07_TRK_NUM, cyl: RP07_CYL_NUM};
      default:  g = '{sec: RP06_SEC_NUM, trk: RP06_TRK_NUM, cyl: RP06_CYL_NUM};
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rpxx_wrapcnt.sv
// rpxx_wrapcnt: one stage of the sector->track->cylinder carry chain.
//  Ports:
//   clk, rst  clock, async active-high reset (q -> 0)
//   load      load ldVal on the next edge
//   ldVal     value to load
//   preset    clear q on the next edge (beats load and cin)
//   cin       carry in: advance q, wrapping to 0 after reaching limit
//   limit     last legal value of this field
//   q         current value
//   cout      carry out = cin & (q == limit)
//  A value above limit never equals it, so it simply counts up and
//  rolls over at 2^W without producing a carry.
module rpxx_wrapcnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ldVal,
  input  logic         preset,
  input  logic         cin,
  input  logic [W-1:0] limit,
  output logic [W-1:0] q,
  output logic         cout
);

  logic [W-1:0] q_r;
  logic [W-1:0] q_nxt_s;
  logic         at_lim_s;

  assign at_lim_s = (q_r == limit);
  assign cout     = cin & at_lim_s;
  assign q        = q_r;

  // Next value: preset > load > carry-in advance
  always_comb begin
    q_nxt_s = q_r;
    if (preset) begin
      q_nxt_s = {W{1'b0}};
    end else if (load) begin
      q_nxt_s = ldVal;
    end else if (cin) begin
      q_nxt_s = at_lim_s ? {W{1'b0}} : (q_r + W'(1'b1));
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Field register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {W{1'b0}};
    end else begin
      q_r <= q_nxt_s;
    end
  end

endmodule

// File: rtl/rpxx_disk_addr.sv
// rpxx_disk_addr: sector/track/cylinder address unit for one RPxx drive.
//  Ports:
//   clk, rst          clock, async active-high reset
//   dataI             register write data
//   daWRITE/dcWRITE   RPDA / RPDC write strobes (honoured only if drvRDY)
//   preset            zero all addresses and aoe
//   clrERR            clear aoe (an overflow in the same cycle wins)
//   drvRDY            drive ready
//   incSect           advance the address by one sector
//   secNum/trkNum/cylNum  last legal sector/track/cylinder
//   rpDA, rpDC        packed register images, unused bits zero
//   lastBlk           address is the last block of the pack (combinational)
//   aoe               sticky address-overflow error
//   iae               illegal address, one cycle behind the address/geometry
//   rmr               one-cycle pulse after a refused register write
module rpxx_disk_addr
  import rpxx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SA_W   = DEF_SA_W,
  parameter int TA_W   = DEF_TA_W,
  parameter int CA_W   = DEF_CA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dataI,
  input  logic              daWRITE,
  input  logic              dcWRITE,
  input  logic              preset,
  input  logic              clrERR,
  input  logic              drvRDY,
  input  logic              incSect,
  input  logic [SA_W-1:0]   secNum,
  input  logic [TA_W-1:0]   trkNum,
  input  logic [CA_W-1:0]   cylNum,
  output logic [15:0]       rpDA,
  output logic [15:0]       rpDC,
  output logic              lastBlk,
  output logic              aoe,
  output logic              iae,
  output logic              rmr
);

  logic            wr_req_s, wr_acc_s, da_ld_s, dc_ld_s, inc_s;
  logic            cs_s, ct_s, ovf_s;
  logic [SA_W-1:0] sa_s;
  logic [TA_W-1:0] ta_s;
  logic [CA_W-1:0] ca_s;
  logic            aoe_r, iae_r, rmr_r;
  logic            aoe_nxt_s, iae_nxt_s, rmr_nxt_s;
  logic            unused_data_s;

  // Only the address fields of dataI are used; fold the rest away.
  assign unused_data_s = ^dataI;

  assign wr_req_s = daWRITE | dcWRITE;
  assign wr_acc_s = wr_req_s & drvRDY;
  // preset is fed straight into every counter, so loads need no extra gating.
  assign da_ld_s  = daWRITE & drvRDY;
  assign dc_ld_s  = dcWRITE & drvRDY;
  // An increment colliding with a write or preset is dropped, not deferred.
  assign inc_s    = incSect & ~preset & ~wr_acc_s;

  rpxx_wrapcnt #(.W(SA_W)) u_sa (
    .clk(clk), .rst(rst), .load(da_ld_s), .ldVal(dataI[rpDA_SA_LSB +: SA_W]),
    .preset(preset), .cin(inc_s), .limit(secNum), .q(sa_s), .cout(cs_s)
  );

  rpxx_wrapcnt #(.W(TA_W)) u_ta (
    .clk(clk), .rst(rst), .load(da_ld_s), .ldVal(dataI[rpDA_TA_LSB +: TA_W]),
    .preset(preset), .cin(cs_s), .limit(trkNum), .q(ta_s), .cout(ct_s)
  );

  rpxx_wrapcnt #(.W(CA_W)) u_ca (
    .clk(clk), .rst(rst), .load(dc_ld_s), .ldVal(dataI[rpDC_CA_LSB +: CA_W]),
    .preset(preset), .cin(ct_s), .limit(cylNum), .q(ca_s), .cout(ovf_s)
  );

  // Status next-state: aoe priority preset > overflow set > clear
  always_comb begin
    aoe_nxt_s = aoe_r;
    if (preset) begin
      aoe_nxt_s = 1'b0;
    end else if (ovf_s) begin
      aoe_nxt_s = 1'b1;
    end else if (wr_acc_s | clrERR) begin
      aoe_nxt_s = 1'b0;
    end else begin
      aoe_nxt_s = aoe_r;
    end
    iae_nxt_s = (sa_s > secNum) | (ta_s > trkNum) | (ca_s > cylNum);
    // preset overrides everything that cycle, including the refusal report
    rmr_nxt_s = wr_req_s & ~drvRDY & ~preset;
  end

  // Status flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aoe_r <= 1'b0;
      iae_r <= 1'b0;
      rmr_r <= 1'b0;
    end else begin
      aoe_r <= aoe_nxt_s;
      iae_r <= iae_nxt_s;
      rmr_r <= rmr_nxt_s;
    end
  end

  assign aoe     = aoe_r;
  assign iae     = iae_r;
  assign rmr     = rmr_r;
  assign lastBlk = (sa_s == secNum) & (ta_s == trkNum) & (ca_s == cylNum);
  assign rpDA    = (16'(ta_s) << rpDA_TA_LSB) | (16'(sa_s) << rpDA_SA_LSB);
  assign rpDC    = 16'(ca_s) << rpDC_CA_LSB;

endmodule

// File: tb/tb_rpxx_disk_addr.sv
// Scoreboard bench for rpxx_disk_addr (SA_W=5, TA_W=5, CA_W=16).
// Stimulus is applied on the falling edge; the reference model pushes the
// expected post-edge outputs, and a monitor pops/compares after each rising edge.
module tb_rpxx_disk_addr;

  localparam int SW = 5;
  localparam int TW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [35:0]   dataI = '0;
  logic          daWRITE = 1'b0, dcWRITE = 1'b0, preset = 1'b0, clrERR = 1'b0;
  logic          drvRDY = 1'b1, incSect = 1'b0;
  logic [SW-1:0] secNum = 5'd19;
  logic [TW-1:0] trkNum = 5'd18;
  logic [CW-1:0] cylNum = 16'd814;
  logic [15:0]   rpDA, rpDC;
  logic          lastBlk, aoe, iae, rmr;

  rpxx_disk_addr #(.DATA_W(36), .SA_W(SW), .TA_W(TW), .CA_W(CW)) dut (
    .clk(clk), .rst(rst), .dataI(dataI), .daWRITE(daWRITE), .dcWRITE(dcWRITE),
    .preset(preset), .clrERR(clrERR), .drvRDY(drvRDY), .incSect(incSect),
    .secNum(secNum), .trkNum(trkNum), .cylNum(cylNum),
    .rpDA(rpDA), .rpDC(rpDC), .lastBlk(lastBlk), .aoe(aoe), .iae(iae), .rmr(rmr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] da;
    logic [15:0] dc;
    logic        aoe;
    logic        iae;
    logic        rmr;
    logic        lb;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: address as plain integers
  int m_sa = 0, m_ta = 0, m_ca = 0;
  bit m_aoe = 0, m_iae = 0, m_rmr = 0;

  // Advance one sector; returns 1 on end-of-pack overflow.
  function automatic bit model_advance(int sec, int trk, int cyl);
    int idx, total;
    bit ovf;
    ovf = 0;
    if (m_sa <= sec && m_ta <= trk && m_ca <= cyl) begin
      // In range: linear block number through the whole pack
      idx   = (m_ca * (trk + 1) + m_ta) * (sec + 1) + m_sa + 1;
      total = (cyl + 1) * (trk + 1) * (sec + 1);
      if (idx == total) begin
        idx = 0;
        ovf = 1;
      end
      m_sa = idx % (sec + 1);
      m_ta = (idx / (sec + 1)) % (trk + 1);
      m_ca = idx / ((sec + 1) * (trk + 1));
    end else if (m_sa != sec) begin
      // Sector not at its last value: it just counts, modulo field width
      m_sa = (m_sa + 1) % (1 << SW);
    end else begin
      m_sa = 0;
      if (m_ta != trk) begin
        m_ta = (m_ta + 1) % (1 << TW);
      end else begin
        m_ta = 0;
        if (m_ca != cyl) begin
          m_ca = (m_ca + 1) % (1 << CW);
        end else begin
          m_ca = 0;
          ovf  = 1;
        end
      end
    end
    return ovf;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.da  = 16'((m_ta << 8) | m_sa);
    e.dc  = 16'(m_ca);
    e.aoe = m_aoe;
    e.iae = m_iae;
    e.rmr = m_rmr;
    e.lb  = (m_sa == int'(secNum)) && (m_ta == int'(trkNum)) && (m_ca == int'(cylNum));
    return e;
  endfunction

  // One cycle: drive inputs on the falling edge, predict, wait a full clock.
  task automatic step(input bit da, input bit dc, input bit pre, input bit clr,
                      input bit rdy, input bit inc, input logic [35:0] d);
    bit req, ovf;
    daWRITE = da; dcWRITE = dc; preset = pre; clrERR = clr;
    drvRDY = rdy; incSect = inc; dataI = d;
    req   = da | dc;
    m_iae = (m_sa > int'(secNum)) || (m_ta > int'(trkNum)) || (m_ca > int'(cylNum));
    m_rmr = req && !rdy && !pre;
    if (pre) begin
      m_sa = 0; m_ta = 0; m_ca = 0; m_aoe = 0;
    end else if (req && rdy) begin
      if (da) begin
        m_sa = int'(d[SW-1:0]);
        m_ta = int'(d[8 +: TW]);
      end
      if (dc) m_ca = int'(d[CW-1:0]);
      m_aoe = 0;
    end else begin
      ovf = inc ? model_advance(int'(secNum), int'(trkNum), int'(cylNum)) : 1'b0;
      if (ovf) m_aoe = 1;
      else if (clr) m_aoe = 0;
    end
    sbq.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 1, 0, 36'd0);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest prediction after each edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      vectors++;
      if (rpDA !== e.da || rpDC !== e.dc || aoe !== e.aoe || iae !== e.iae ||
          rmr !== e.rmr || lastBlk !== e.lb) begin
        miscompares++;
        $display("FAIL sb t=%0t: got da=%04h dc=%04h aoe=%b iae=%b rmr=%b lb=%b expected da=%04h dc=%04h aoe=%b iae=%b rmr=%b lb=%b",
                 $time, rpDA, rpDC, aoe, iae, rmr, lastBlk,
                 e.da, e.dc, e.aoe, e.iae, e.rmr, e.lb);
      end
    end
  end

  initial begin
    logic [35:0] d;
    int r;
    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_da", rpDA, 16'h0000);
    chk("rst_flags", {12'd0, aoe, iae, rmr, lastBlk}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-run with SA=5 and a refused write pending
    step(1, 0, 0, 0, 1, 0, 36'h0005);
    chk("pre_rst_da", rpDA, 16'h0005);
    daWRITE = 1'b1; drvRDY = 1'b0; dataI = 36'h0102;
    rst = 1'b1;
    #1;
    chk("midrst_da", rpDA, 16'h0000);
    chk("midrst_flags", {12'd0, aoe, iae, rmr, lastBlk}, 16'h0000);
    m_sa = 0; m_ta = 0; m_ca = 0; m_aoe = 0; m_iae = 0; m_rmr = 0;
    @(negedge clk);
    chk("midrst_rmr", {15'd0, rmr}, 16'h0000);
    daWRITE = 1'b0; drvRDY = 1'b1; rst = 1'b0;
    idle();
    chk("postrst_rmr", {15'd0, rmr}, 16'h0000);

    // RP06 carry chain and end of pack
    step(1, 1, 0, 0, 1, 0, {20'd0, 16'h1213} | 36'd813 << 0 & 36'h0);
    step(0, 1, 0, 0, 1, 0, 36'd813);
    step(1, 0, 0, 0, 1, 0, 36'h1213);
    step(0, 0, 0, 0, 1, 1, 36'd0);
    chk("rp06_inc_da", rpDA, 16'h0000);
    chk("rp06_inc_dc", rpDC, 16'd814);
    chk("rp06_inc_flags", {14'd0, aoe, lastBlk}, 16'h0000);
    step(1, 0, 0, 0, 1, 0, 36'h1213);
    chk("rp06_last", {15'd0, lastBlk}, 16'h0001);
    step(0, 0, 0, 0, 1, 1, 36'd0);
    chk("eop_da", rpDA, 16'h0000);
    chk("eop_dc", rpDC, 16'h0000);
    chk("eop_aoe", {15'd0, aoe}, 16'h0001);

    // Simultaneous events
    step(1, 0, 0, 0, 1, 1, 36'h0305);
    chk("wr_vs_inc", rpDA, 16'h0305);
    chk("wr_clr_aoe", {15'd0, aoe}, 16'h0000);
    step(1, 0, 1, 0, 1, 0, 36'h0A07);
    chk("preset_vs_wr", rpDA, 16'h0000);
    step(1, 1, 0, 0, 1, 0, 36'h1213);
    step(0, 1, 0, 0, 1, 0, 36'd814);
    step(0, 0, 0, 1, 1, 1, 36'd0);
    chk("clr_vs_ovf", {15'd0, aoe}, 16'h0001);

    // Refused write
    step(1, 0, 0, 0, 1, 0, 36'h0004);
    step(1, 0, 0, 0, 0, 0, 36'h0102);
    chk("refused_da", rpDA, 16'h0004);
    chk("refused_rmr", {15'd0, rmr}, 16'h0001);
    idle();
    chk("rmr_pulse", {15'd0, rmr}, 16'h0000);

    // Illegal address tracking
    step(1, 0, 0, 0, 1, 0, 36'h0019);
    chk("iae_lat", {15'd0, iae}, 16'h0000);
    idle();
    chk("iae_set", {15'd0, iae}, 16'h0001);
    step(1, 0, 0, 0, 1, 0, 36'h0003);
    idle();
    chk("iae_clr", {15'd0, iae}, 16'h0000);
    step(0, 1, 0, 0, 1, 0, 36'd814);
    cylNum = 16'd410;
    idle();
    chk("iae_geom", {15'd0, iae}, 16'h0001);
    // Out-of-range counting: CA stays above limit, SA keeps going
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 1, 1, 36'd0);

    // Randomized run over several geometries
    for (int i = 0; i < 10000; i++) begin
      if (i % 400 == 0) begin
        r = int'($urandom_range(0, 3));
        case (r)
          0: begin secNum = 5'd19; trkNum = 5'd18; cylNum = 16'd814; end
          1: begin secNum = 5'd31; trkNum = 5'd31; cylNum = 16'hFFFF; end
          2: begin
            secNum = 5'($urandom_range(0, 3));
            trkNum = 5'($urandom_range(0, 3));
            cylNum = 16'($urandom_range(0, 3));
          end
          default: begin
            secNum = 5'($urandom); trkNum = 5'($urandom); cylNum = 16'($urandom);
          end
        endcase
      end
      d = {$urandom, $urandom};
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 1) == 1) begin
        if (r < 6)
          d[15:0] = 16'($urandom_range(0, int'(cylNum) + 1));
        else
          d[15:0] = {3'd0, 5'($urandom_range(0, int'(trkNum) + 1)),
                     3'd0, 5'($urandom_range(0, int'(secNum) + 1))};
      end
      step((r >= 6 && r < 12) || r == 99,
           (r < 6) || r == 99,
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 6),
           ($urandom_range(0, 99) < 88),
           ($urandom_range(0, 99) < 70),
           d);
    end
    idle();
    @(negedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
